// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial arithmetic units.
// The state codes are kept stable because other serial units reuse them.
package serial_adder_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/serial_adder_full_add.sv
// Single-bit full adder cell.
// It is purely combinational and has the same port layout as the full subtractor cell.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. It handles one bit per clock, starting with the LSB, through one full-adder cell.
// The result is presented together with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nxt;
    logic             carry, fa_s, fa_co, last;
    logic [CNT_W-1:0] cnt;

    full_add u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    // The sum bits enter at the MSB, so after WIDTH shifts bit 0 is in place.
    assign s_nxt = {fa_s, s_sh[WIDTH-1:1]};
    assign last  = (cnt == CNT_W'(WIDTH - 1));
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        s_sh  <= '0;
                        carry <= cin;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_nxt;
                    carry <= fa_co;
                    cnt   <= cnt + CNT_W'(1);
                    // The result registers are written only on the final bit, so they never hold a partial sum.
                    if (last) begin
                        sum   <= s_nxt;
                        cout  <= fa_co;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder with WIDTH=8.
// The reference model is plain integer addition of a + b + cin.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             cin = 1'b0;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_exp = '0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Waits for done and counts the busy cycles seen before it.
    // While the unit is running, the result must still hold the previous value.
    task automatic wait_done(input string tag, output int nbusy);
        int k;
        nbusy = 0;
        k = 0;
        while (!done && k < 40) begin
            if (busy) nbusy++;
            chk({tag, "_hold"}, 32'({cout, sum}), last_exp);
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    // Runs one operation with a one-cycle start pulse and checks it against the model.
    task automatic run_op(input string tag, input logic [7:0] oa, input logic [7:0] ob, input logic oc);
        int          nb;
        logic [31:0] exp;
        exp = 32'(oa) + 32'(ob) + 32'(oc);
        a = oa; b = ob; cin = oc; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~oa; b = ~ob; cin = ~oc;   // the operands have already been captured
        wait_done(tag, nb);
        chk({tag, "_busy_cycles"}, 32'(nb), 32'(WIDTH));
        chk({tag, "_result"}, 32'({cout, sum}), exp);
        last_exp = exp;
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_stay_valid"}, 32'({cout, sum}), exp);
    endtask

    initial begin
        int nb, k;
        int gap;

        // Reset
        rst = 1'b1;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        // Directed operations
        run_op("add_3c_05", 8'h3C, 8'h05, 1'b0);
        chk("add_3c_05_val", 32'({cout, sum}), 32'h041);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        chk("add_ff_01_val", 32'({cout, sum}), 32'h100);
        run_op("add_ff_ff_1", 8'hFF, 8'hFF, 1'b1);
        chk("add_ff_ff_1_val", 32'({cout, sum}), 32'h1FF);
        run_op("sub_10_03", 8'h10, 8'hFC, 1'b1);
        chk("sub_10_03_val", 32'({cout, sum}), 32'h10D);

        // Start held high: runs go back to back, one result every WIDTH+1 cycles
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        wait_done("held0", nb);
        chk("held0_sum", 32'({cout, sum}), 32'h002);
        last_exp = 32'h002;
        for (int r = 1; r <= 2; r++) begin
            k = 0;
            do begin
                tick();
                k++;
                if (r == 2 && k == 3) a = 8'h7F;   // a change in the middle of a run must not affect the result
                if (!done) chk("held_hold", 32'({cout, sum}), last_exp);
            end while (!done && k < 40);
            chk("held_period", 32'(k), 32'(WIDTH + 1));
            chk("held_sum", 32'({cout, sum}), 32'h002);
        end
        start = 1'b0;
        a = 8'h01;
        tick();
        chk("held_idle_busy", 32'(busy), 32'd0);
        chk("held_idle_done", 32'(done), 32'd0);

        // Reset in the 4th RUN cycle aborts the run with no done pulse
        a = 8'h11; b = 8'h22; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        last_exp = '0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
        end
        run_op("post_abort", 8'h20, 8'h20, 1'b0);
        chk("post_abort_val", 32'({cout, sum}), 32'h040);

        // Random operations with random idle gaps
        for (int i = 0; i < 1000; i++) begin
            gap = int'($urandom_range(3));
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("rand_gap_hold", 32'({cout, sum}), last_exp);
            end
            run_op("rand", 8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
